// File: rtl/ld_st_rg_arbiter.sv
// Round-robin arbiter that shares one load/store register bank between two requesters.
// Each granted LOAD/PRESET drives the bank for one cycle, then reads back, checks and acks.
module ld_st_rg_arbiter #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         req0,
  input  logic         req1,
  input  logic         op0,
  input  logic         op1,
  input  logic [n-1:0] din0,
  input  logic [n-1:0] din1,
  input  logic [n-1:0] rg_dout,
  output logic         rg_set,
  output logic         rg_l_s,
  output logic [n-1:0] rg_din,
  output logic         ack0,
  output logic         ack1,
  output logic         err,
  output logic         busy,
  output logic [n-1:0] q
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, ACK} state_t;

  state_t       state, state_nxt;
  logic         rr;
  logic         gnt;
  logic         op_h;
  logic         mis;
  logic [n-1:0] din_h;
  logic [n-1:0] exp_h;
  logic         win;
  logic         grant;

  // With both requests high the rr pointer picks; otherwise the lone requester wins.
  always_comb begin
    win   = (req0 && req1) ? rr : req1;
    grant = (state == IDLE) && (req0 || req1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      rr    <= 1'b0;
      gnt   <= 1'b0;
      op_h  <= 1'b0;
      mis   <= 1'b0;
      din_h <= '0;
      exp_h <= '0;
      q     <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt   <= win;
        rr    <= ~win;
        op_h  <= win ? op1 : op0;
        din_h <= win ? din1 : din0;
        exp_h <= (win ? op1 : op0) ? '1 : (win ? din1 : din0);
      end
      if (state == CHECK) begin
        q   <= rg_dout;
        mis <= (rg_dout != exp_h);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rg_set    = 1'b0;
    rg_l_s    = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    err       = 1'b0;
    busy      = (state != IDLE);
    rg_din    = din_h;
    case (state)
      IDLE:  if (grant) state_nxt = DRIVE;
      DRIVE: begin
        rg_set    = op_h;
        rg_l_s    = ~op_h;
        state_nxt = CHECK;
      end
      CHECK: state_nxt = ACK;
      ACK: begin
        ack0      = ~gnt;
        ack1      = gnt;
        err       = mis;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ld_st_rg_arbiter.sv
// Bench for ld_st_rg_arbiter: a behavioural bank with fault injection plus a
// transaction-level model that predicts every output cycle by cycle.
module tb_ld_st_rg_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         req0, req1, op0, op1;
  logic [N-1:0] din0, din1, rg_dout;
  logic         rg_set, rg_l_s, ack0, ack1, err, busy;
  logic [N-1:0] rg_din, q;

  logic [N-1:0] bank = '0;
  logic [N-1:0] fault_mask = '0;

  ld_st_rg_arbiter #(.n(N)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .din0(din0), .din1(din1), .rg_dout(rg_dout),
    .rg_set(rg_set), .rg_l_s(rg_l_s), .rg_din(rg_din),
    .ack0(ack0), .ack1(ack1), .err(err), .busy(busy), .q(q)
  );

  always #5 clk = ~clk;

  // Attached bank: set forces all ones, l_s loads; output may be corrupted on purpose.
  always @(posedge clk) begin
    if (rg_set) bank <= '1;
    else if (rg_l_s) bank <= rg_din;
  end
  assign rg_dout = bank ^ fault_mask;

  int checks = 0;
  int failures = 0;

  // Transaction model: an op granted in cycle `start` occupies the next three cycles.
  int           k = 0;
  int           start = 0;
  bit           act = 0;
  bit           m_rr = 0;
  bit           m_gnt = 0;
  bit           m_op = 0;
  logic [N-1:0] m_din = '0;
  logic [N-1:0] m_mask = '0;
  logic [N-1:0] m_q = '0;
  int           phase;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    act = 0; m_rr = 0; m_gnt = 0; m_op = 0; m_din = '0; m_q = '0; m_mask = '0;
  endtask

  task automatic check_outputs();
    phase = act ? (k - start) : -1;
    if (phase >= 4) begin
      act = 0;
      phase = -1;
    end
    if (phase == 3) m_q = (m_op ? {N{1'b1}} : m_din) ^ m_mask;
    chk("rg_set", 32'(rg_set), 32'(phase == 1 && m_op));
    chk("rg_l_s", 32'(rg_l_s), 32'(phase == 1 && !m_op));
    chk("rg_din", 32'(rg_din), 32'(m_din));
    chk("busy",   32'(busy),   32'(phase >= 1 && phase <= 3));
    chk("ack0",   32'(ack0),   32'(phase == 3 && !m_gnt));
    chk("ack1",   32'(ack1),   32'(phase == 3 && m_gnt));
    chk("err",    32'(err),    32'(phase == 3 && m_mask != '0));
    chk("q",      32'(q),      32'(m_q));
  endtask

  // One clock cycle: check this cycle's outputs, then apply inputs sampled at the next edge.
  task automatic step(input bit r0, input bit r1, input bit o0, input bit o1,
                      input logic [N-1:0] d0, input logic [N-1:0] d1, input logic [N-1:0] mask);
    bit w;
    @(posedge clk);
    #1;
    k++;
    check_outputs();
    req0 = r0; req1 = r1; op0 = o0; op1 = o1; din0 = d0; din1 = d1;
    fault_mask = (phase == 2) ? m_mask : '0;
    if (phase == -1 && (r0 || r1)) begin
      w      = (r0 && r1) ? m_rr : r1;
      m_rr   = !w;
      m_gnt  = w;
      m_op   = w ? o1 : o0;
      m_din  = w ? d1 : d0;
      m_mask = mask;
      act    = 1;
      start  = k;
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    req0 = 0; req1 = 0; op0 = 0; op1 = 0; din0 = '0; din1 = '0;
    do_reset();

    // Single LOAD then PRESET, each followed by idle cycles.
    step(1, 0, 0, 0, 4'hA, 4'h0, 4'h0);
    repeat (5) step(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    step(0, 1, 0, 1, 4'h0, 4'h6, 4'h0);
    repeat (5) step(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);

    // Read-back fault: LOAD 5 observed as 0.
    step(1, 0, 0, 0, 4'h5, 4'h0, 4'h5);
    repeat (5) step(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);

    // Early drop with op/din changing after grant.
    step(1, 0, 0, 0, 4'h9, 4'h0, 4'h0);
    repeat (5) step(0, 0, 1, 1, 4'h2, 4'h2, 4'h0);

    // Reset asserted during DRIVE aborts the op.
    step(1, 0, 0, 0, 4'h7, 4'h0, 4'h0);
    step(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    #1;
    do_reset();
    repeat (5) step(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);

    // Contention straight out of reset: grants alternate 0,1,0,1.
    do_reset();
    repeat (18) step(1, 1, 0, 0, 4'h3, 4'hC, 4'h0);
    repeat (4) step(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);

    // Randomized traffic with occasional read-back faults.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           1'($urandom), 1'($urandom), N'($urandom), N'($urandom),
           ($urandom_range(0, 4) == 0) ? N'($urandom) : '0);
    end
    repeat (5) step(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
